// File: rtl/param_signed_multiplier.sv
// Sequential shift-add multiplier for signed or unsigned operands with a start/busy/done handshake.
// Works on operand magnitudes, one multiplier bit per clock, and applies the sign in a final fix-up cycle.
module param_signed_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 sign,
    output logic                 zflag
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mplr_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic                 zero_q;

    // The most-negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic smode);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        return (smode && sv < 0) ? $unsigned(-sv) : v;
    endfunction

    function automatic logic signed [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                             input logic neg);
        logic signed [2*WIDTH-1:0] s;
        s = $signed(mag);
        return neg ? -s : s;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            sign    <= 1'b0;
            zflag   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state == FIX);
            if (state == FIX) begin
                product <= apply_sign(acc_q, neg_q);
                sign    <= neg_q & ~zero_q;
                zflag   <= zero_q;
            end
        end
    end

    // Datapath: shifting the multiplicand left each step is the same as adding it shifted by cnt.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            mplr_q  <= magnitude(multiplier, signed_mode);
            mcand_q <= {{WIDTH{1'b0}}, magnitude(multiplicand, signed_mode)};
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
            zero_q  <= (multiplier == '0) || (multiplicand == '0);
        end else if (state == RUN) begin
            if (mplr_q[0]) acc_q <= acc_q + mcand_q;
            mplr_q  <= mplr_q >> 1;
            mcand_q <= mcand_q << 1;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_param_signed_multiplier.sv
// Randomised and directed bench for param_signed_multiplier (WIDTH=8 main instance, WIDTH=4 side instance).
// A cycle-level arithmetic model predicts every output of the 8-bit instance each cycle.
module tb_param_signed_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  multiplier = '0;
    logic [7:0]  multiplicand = '0;
    logic        busy, done, sign, zflag;
    logic [15:0] product;

    logic        start4 = 1'b0;
    logic        signed_mode4 = 1'b0;
    logic [3:0]  multiplier4 = '0;
    logic [3:0]  multiplicand4 = '0;
    logic        busy4, done4, sign4, zflag4;
    logic [7:0]  product4;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    param_signed_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .multiplier(multiplier), .multiplicand(multiplicand),
        .busy(busy), .done(done), .product(product), .sign(sign), .zflag(zflag)
    );

    param_signed_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(signed_mode4),
        .multiplier(multiplier4), .multiplicand(multiplicand4),
        .busy(busy4), .done(done4), .product(product4), .sign(sign4), .zflag(zflag4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: result is the true integer product taken modulo 2^16.
    int          cyc = 0;
    int          due = 0;
    bit          pend = 1'b0;
    logic        e_busy = 1'b0, e_done = 1'b0, e_sign = 1'b0, e_z = 1'b0;
    logic [15:0] e_prod = '0;
    logic [15:0] q_prod;
    logic        q_sign, q_z;

    always @(posedge clk) begin
        longint av, bv, p;
        cyc++;
        if (rst) begin
            pend = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_prod = '0; e_sign = 1'b0; e_z = 1'b0;
        end else begin
            e_done = 1'b0;
            if (pend && cyc == due) begin
                e_done = 1'b1; e_prod = q_prod; e_sign = q_sign; e_z = q_z;
                pend = 1'b0;
            end else if (!pend && start) begin
                if (signed_mode) begin
                    av = longint'($signed(multiplier));
                    bv = longint'($signed(multiplicand));
                end else begin
                    av = longint'(multiplier);
                    bv = longint'(multiplicand);
                end
                p      = av * bv;
                q_prod = p[15:0];
                q_sign = (p < 0);
                q_z    = (p == 0);
                pend   = 1'b1;
                due    = cyc + 9;
            end
            e_busy = pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("product", 32'(product), 32'(e_prod));
            chk("sign", 32'(sign), 32'(e_sign));
            chk("zflag", 32'(zflag), 32'(e_z));
        end
    end

    // Called at a negedge with the unit idle; returns at the negedge after the accepting edge.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        multiplier = a; multiplicand = b; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        multiplier = 8'($urandom); multiplicand = 8'($urandom); signed_mode = 1'($urandom);
    endtask

    task automatic wait_done8(input int first, output int lat);
        lat = -1;
        for (int n = first; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] xp, input logic xs, input logic xz);
        int lat;
        launch8(a, b, sm);
        wait_done8(1, lat);
        chk({name, "_latency"}, 32'(lat), 32'd9);
        chk({name, "_product"}, 32'(product), 32'(xp));
        chk({name, "_sign"}, 32'(sign), 32'(xs));
        chk({name, "_zflag"}, 32'(zflag), 32'(xz));
    endtask

    task automatic op4(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] xp, input logic xs);
        int lat;
        multiplier4 = a; multiplicand4 = b; signed_mode4 = 1'b1; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done4 === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'd5);
        chk({name, "_product"}, 32'(product4), 32'(xp));
        chk({name, "_sign"}, 32'(sign4), 32'(xs));
    endtask

    initial begin
        int lat;
        int seen;
        logic [7:0] corners [6];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFD};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_product", 32'(product), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset4_product", 32'(product4), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op8("t1_7x-3", 8'h07, 8'hFD, 1'b1, 16'hFFEB, 1'b1, 1'b0);
        op8("t2_-128sq", 8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 1'b0);
        op8("t2_-1x1", 8'hFF, 8'h01, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        op8("t3_u255sq", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b0);
        op8("t3_s255sq", 8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, 1'b0);
        op8("t4_0x-5", 8'h00, 8'hFB, 1'b1, 16'h0000, 1'b0, 1'b1);

        // Re-pulsed start mid-run must be ignored.
        launch8(8'd12, 8'd11, 1'b0);
        repeat (2) @(negedge clk);
        multiplier = 8'd3; multiplicand = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(4, lat);
        chk("t5_repulse_latency", 32'(lat), 32'd9);
        chk("t5_repulse_product", 32'(product), 32'd132);

        // Reset in the middle of a run aborts it.
        launch8(8'd5, 8'd9, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_product", 32'(product), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("t5_rst_no_done", 32'(seen), 32'd0);
        op8("t5_after_rst", 8'hF6, 8'h0C, 1'b1, 16'hFF88, 1'b1, 1'b0);

        op4("t6_-8x-8", 4'h8, 4'h8, 8'h40, 1'b0);
        op4("t6_-8x7", 4'h8, 4'h7, 8'hC8, 1'b1);

        // Back-to-back: start held high, operands changing every cycle.
        start = 1'b1;
        repeat (45) begin
            multiplier = 8'($urandom); multiplicand = 8'($urandom); signed_mode = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;

        // Random pulses including corner operands and starts while busy.
        repeat (600) begin
            start = ($urandom_range(0, 3) == 0);
            signed_mode = 1'($urandom);
            multiplier = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : 8'($urandom);
            multiplicand = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : 8'($urandom);
            if ($urandom_range(0, 150) == 0) rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
